cdb_arbiter: RTL and testbench

- Common-data-bus writeback stage directly downstream of the functional units (Add and siblings).
- Buffers each FU's result in a small per-FU FIFO and grants one result per cycle, round-robin.
- Drives a single registered broadcast (tag + data) consumed by the register-file and reservation-station broadcast logic.
- Tag value 0 is reserved for "no producer", so FU slot i broadcasts tag i+1.

---
 rtl/cdb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus writeback stage.
// Each functional unit pushes results into its own small FIFO; one result per
// cycle is granted round-robin and broadcast as a registered (tag, data) pair.
// Slot i broadcasts tag i+1 because tag 0 means "no producer".
// Optional feature macro: CDB_ARBITER_STALL_EN adds a cdb_stall input that
// freezes arbitration while enqueues continue.
//
// Handshake: an FU result is accepted on a rising edge exactly when
// fu_valid[i] && fu_ready[i]; fu_ready depends only on the registered FIFO
// count, so an FU whose result is not accepted must hold it unchanged.
// cdb_valid is a one-cycle pulse per result and has no ready/back-pressure
// other than cdb_stall when that feature is built in.
module cdb_arbiter #(
    parameter int NUM_FU     = 3,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     CLOCK_50,
    input  logic                     RST,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*DATA_W-1:0] fu_result,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data
`ifdef CDB_ARBITER_STALL_EN
    ,
    input  logic                     cdb_stall
`endif
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W:0]   NUM_FU_X = (PTR_W + 1)'(NUM_FU);
    localparam logic [PTR_W-1:0] LAST_FU  = PTR_W'(NUM_FU - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] r_mem   [NUM_FU][FIFO_DEPTH];
    logic [AW-1:0]     r_head  [NUM_FU];
    logic [AW-1:0]     r_tail  [NUM_FU];
    logic [CW-1:0]     r_count [NUM_FU];
    logic [PTR_W-1:0]  r_rr_ptr;

    // Registered broadcast
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;

    logic [NUM_FU-1:0] w_ready;
    logic [NUM_FU-1:0] w_not_empty;
    logic [NUM_FU-1:0] w_enq;
    logic [NUM_FU-1:0] w_deq;
    logic [PTR_W:0]    w_cand;
    logic              w_gnt_found;
    logic [PTR_W-1:0]  w_gnt_idx;
    logic              w_stall;
    logic              w_do_grant;
    logic [PTR_W-1:0]  w_rr_next;
    logic [TAG_W-1:0]  w_gnt_tag;
    logic [DATA_W-1:0] w_gnt_data;

`ifdef CDB_ARBITER_STALL_EN
    assign w_stall = cdb_stall;
`else
    assign w_stall = 1'b0;
`endif

    // Per-FIFO status from registered counts only (no dequeue bypass)
    always_comb begin
        w_ready     = '0;
        w_not_empty = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_ready[i]     = (r_count[i] != FULL_CNT);
            w_not_empty[i] = (r_count[i] != '0);
        end
    end

    assign w_enq = fu_valid & w_ready;

    // Round-robin search: first non-empty FIFO at or after r_rr_ptr
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (PTR_W + 1)'(k);
            if (w_cand >= NUM_FU_X) begin
                w_cand = w_cand - NUM_FU_X;
            end
            if (!w_gnt_found && w_not_empty[w_cand[PTR_W-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_cand[PTR_W-1:0];
            end
        end
    end

    assign w_do_grant = w_gnt_found & ~w_stall;
    assign w_rr_next  = (w_gnt_idx == LAST_FU) ? '0 : w_gnt_idx + PTR_W'(1);
    assign w_gnt_tag  = TAG_W'(w_gnt_idx) + TAG_W'(1);
    assign w_gnt_data = r_mem[w_gnt_idx][r_head[w_gnt_idx]];

    // One-hot dequeue strobe for the granted FIFO
    always_comb begin
        w_deq = '0;
        if (w_do_grant) begin
            w_deq[w_gnt_idx] = 1'b1;
        end
    end

    // FIFO payload writes; contents need no reset since pointers are reset
    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_enq[i]) begin
                r_mem[i][r_tail[i]] <= fu_result[i*DATA_W +: DATA_W];
            end
        end
    end

    // FIFO pointers, counts, round-robin pointer and registered broadcast
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_head[i]  <= '0;
                r_tail[i]  <= '0;
                r_count[i] <= '0;
            end
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_enq[i]) begin
                    r_tail[i] <= r_tail[i] + AW'(1);
                end
                if (w_deq[i]) begin
                    r_head[i] <= r_head[i] + AW'(1);
                end
                if (w_enq[i] && !w_deq[i]) begin
                    r_count[i] <= r_count[i] + CW'(1);
                end else if (!w_enq[i] && w_deq[i]) begin
                    r_count[i] <= r_count[i] - CW'(1);
                end
            end
            if (w_do_grant) begin
                r_cdb_valid <= 1'b1;
                r_cdb_tag   <= w_gnt_tag;
                r_cdb_data  <= w_gnt_data;
                r_rr_ptr    <= w_rr_next;
            end else begin
                r_cdb_valid <= 1'b0;
                r_cdb_tag   <= '0;
                r_cdb_data  <= '0;
            end
        end
    end

    assign fu_ready  = w_ready;
    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_FU=3, DATA_W=32, TAG_W=2, FIFO_DEPTH=2).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cdb_arbiter;

    logic        clk;
    logic        RST;
    logic [2:0]  fu_valid;
    logic [95:0] fu_result;
    logic [2:0]  fu_ready;
    logic        cdb_valid;
    logic [1:0]  cdb_tag;
    logic [31:0] cdb_data;
`ifdef CDB_ARBITER_STALL_EN
    logic        cdb_stall;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    cdb_arbiter #(
        .NUM_FU(3), .DATA_W(32), .TAG_W(2), .FIFO_DEPTH(2)
    ) dut (
        .CLOCK_50 (clk),
        .RST      (RST),
        .fu_valid (fu_valid),
        .fu_result(fu_result),
        .fu_ready (fu_ready),
        .cdb_valid(cdb_valid),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data)
`ifdef CDB_ARBITER_STALL_EN
        ,
        .cdb_stall(cdb_stall)
`endif
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int idx, input logic [31:0] val);
        fu_result[idx*32 +: 32] = val;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic check_cdb(input string name, input logic v, input logic [1:0] t,
                             input logic [31:0] d);
        check({name, ".valid"}, 64'(cdb_valid), 64'(v));
        check({name, ".tag"},   64'(cdb_tag),   64'(t));
        check({name, ".data"},  64'(cdb_data),  64'(d));
    endtask

    logic [2:0]  acc;
    logic [31:0] v0;
    logic [31:0] v2;

    initial begin
        RST       = 1'b1;
        fu_valid  = '0;
        fu_result = '0;
`ifdef CDB_ARBITER_STALL_EN
        cdb_stall = 1'b0;
`endif
        tick();
        tick();
        check_cdb("reset", 1'b0, 2'd0, 32'd0);
        check("reset.ready", 64'(fu_ready), 64'(3'b111));
        RST = 1'b0;

        // Single result on FU1: broadcast two edges later, one cycle only
        set_fu(1, 32'd7);
        fu_valid = 3'b010;
        tick();
        fu_valid = 3'b000;
        check_cdb("single.e0", 1'b0, 2'd0, 32'd0);
        tick();
        check_cdb("single.e1", 1'b1, 2'd2, 32'd7);
        tick();
        check_cdb("single.e2", 1'b0, 2'd0, 32'd0);

        // Contention from rr_ptr=0
        RST = 1'b1;
        tick();
        RST = 1'b0;
        set_fu(0, 32'd10);
        set_fu(1, 32'd20);
        set_fu(2, 32'd30);
        fu_valid = 3'b111;
        tick();
        fu_valid = 3'b000;
        check_cdb("cont.e0", 1'b0, 2'd0, 32'd0);
        tick();
        check_cdb("cont.e1", 1'b1, 2'd1, 32'd10);
        tick();
        check_cdb("cont.e2", 1'b1, 2'd2, 32'd20);
        tick();
        check_cdb("cont.e3", 1'b1, 2'd3, 32'd30);
        tick();
        check_cdb("cont.idle", 1'b0, 2'd0, 32'd0);

        // Fairness: FU0 and FU2 always valid, each holds its value until accepted.
        // rr_ptr should be back at 0, so FU0 wins first.
        v0 = 32'd100;
        v2 = 32'd200;
        for (int n = 0; n < 9; n++) begin
            fu_valid = 3'b101;
            set_fu(0, v0);
            set_fu(2, v2);
            acc = fu_valid & fu_ready;
            tick();
            if (acc[0]) v0 = v0 + 32'd1;
            if (acc[2]) v2 = v2 + 32'd1;
            if (n == 0) begin
                check_cdb("fair.e0", 1'b0, 2'd0, 32'd0);
            end else if (n % 2 == 1) begin
                check_cdb($sformatf("fair.e%0d", n), 1'b1, 2'd1, 32'(100 + (n - 1) / 2));
            end else begin
                check_cdb($sformatf("fair.e%0d", n), 1'b1, 2'd3, 32'(200 + (n - 2) / 2));
            end
            if (n == 1) check("fair.ready.e1", 64'(fu_ready), 64'(3'b011));
            if (n == 2) check("fair.ready.e2", 64'(fu_ready), 64'(3'b110));
        end
        fu_valid = 3'b000;
        RST = 1'b1;
        tick();
        RST = 1'b0;

        // Backpressure: FU0 fills while FU1/FU2 hold the grant, 8 is refused
        set_fu(0, 32'd5);
        set_fu(1, 32'd50);
        set_fu(2, 32'd60);
        fu_valid = 3'b111;
        tick();
        check("bp.ready.e0", 64'(fu_ready), 64'(3'b111));
        fu_valid = 3'b001;
        set_fu(0, 32'd6);
        tick();
        check_cdb("bp.e1", 1'b1, 2'd1, 32'd5);
        set_fu(0, 32'd7);
        tick();
        check_cdb("bp.e2", 1'b1, 2'd2, 32'd50);
        check("bp.ready.e2", 64'(fu_ready), 64'(3'b110));
        set_fu(0, 32'd8);
        tick();
        check_cdb("bp.e3", 1'b1, 2'd3, 32'd60);
        check("bp.ready.e3", 64'(fu_ready), 64'(3'b110));
        fu_valid = 3'b000;
        tick();
        check_cdb("bp.e4", 1'b1, 2'd1, 32'd6);
        check("bp.ready.e4", 64'(fu_ready), 64'(3'b111));
        tick();
        check_cdb("bp.e5", 1'b1, 2'd1, 32'd7);
        tick();
        check_cdb("bp.e6", 1'b0, 2'd0, 32'd0);

        // Reset mid-operation discards the entry still held in FU1
        set_fu(1, 32'h11);
        fu_valid = 3'b010;
        tick();
        set_fu(1, 32'h22);
        tick();
        check_cdb("rst.e1", 1'b1, 2'd2, 32'h11);
        fu_valid = 3'b000;
        RST = 1'b1;
        tick();
        check_cdb("rst.e2", 1'b0, 2'd0, 32'd0);
        check("rst.ready", 64'(fu_ready), 64'(3'b111));
        RST = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check_cdb($sformatf("rst.after%0d", n), 1'b0, 2'd0, 32'd0);
        end

        // Wrap-around: 8 results streamed through FU2, one grant per edge
        for (int k = 0; k < 8; k++) begin
            fu_valid = 3'b100;
            set_fu(2, 32'(300 + k));
            tick();
            if (k == 0) begin
                check_cdb("wrap.e0", 1'b0, 2'd0, 32'd0);
            end else begin
                check_cdb($sformatf("wrap.e%0d", k), 1'b1, 2'd3, 32'(300 + k - 1));
            end
        end
        fu_valid = 3'b000;
        tick();
        check_cdb("wrap.e8", 1'b1, 2'd3, 32'd307);
        tick();
        check_cdb("wrap.idle", 1'b0, 2'd0, 32'd0);

`ifdef CDB_ARBITER_STALL_EN
        // Stall: FU0 fills to depth, 7 refused, then 5 and 6 drain
        RST = 1'b1;
        tick();
        RST = 1'b0;
        cdb_stall = 1'b1;
        fu_valid  = 3'b001;
        set_fu(0, 32'd5);
        tick();
        check_cdb("stall.e0", 1'b0, 2'd0, 32'd0);
        set_fu(0, 32'd6);
        tick();
        check_cdb("stall.e1", 1'b0, 2'd0, 32'd0);
        check("stall.ready.e1", 64'(fu_ready), 64'(3'b110));
        set_fu(0, 32'd7);
        tick();
        check_cdb("stall.e2", 1'b0, 2'd0, 32'd0);
        check("stall.ready.e2", 64'(fu_ready), 64'(3'b110));
        fu_valid  = 3'b000;
        cdb_stall = 1'b0;
        tick();
        check_cdb("stall.e3", 1'b1, 2'd1, 32'd5);
        check("stall.ready.e3", 64'(fu_ready), 64'(3'b111));
        tick();
        check_cdb("stall.e4", 1'b1, 2'd1, 32'd6);
        tick();
        check_cdb("stall.e5", 1'b0, 2'd0, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
